// File: rtl/dmem_pkg.sv
// Shared types for the data-memory access unit: store-buffer entry layout,
// error codes and default sizing.
package dmem_pkg;

  localparam int MEM_WORDS_DEFAULT = 10;
  localparam int SB_DEPTH_DEFAULT  = 2;

  typedef struct packed {
    logic [29:0] idx;
    logic [31:0] data;
    logic        sb;
  } sb_entry_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_RANGE    = 2'b10
  } err_code_t;

  function automatic logic [31:0] word_addr(input logic [29:0] idx);
    return {idx, 2'b00};
  endfunction

endpackage

// File: rtl/dmem_access_unit_if.sv
// Pipeline-side request/response bundle of the data-memory access unit.
// The pipeline is the master, the access unit is the slave.
interface dmem_access_unit_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic        req_sb;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        err;
  logic [1:0]  err_code;

  modport master (
    output req_valid, req_we, req_sb, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, err, err_code
  );

  modport slave (
    input  req_valid, req_we, req_sb, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, err, err_code
  );

endinterface

// File: rtl/dmem_access_unit_store_buf_fifo.sv
// Posted store buffer: circular FIFO of sb_entry_t with a per-entry word-index
// match vector and the youngest matching entry (used for load forwarding).
module store_buf_fifo
  import dmem_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEFAULT,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  sb_entry_t        push_entry,
  input  logic             pop,
  input  logic [29:0]      match_idx,
  output logic             full,
  output logic             empty,
  output sb_entry_t        head,
  output logic [DEPTH-1:0] match_vec,
  output logic             youngest_hit,
  output sb_entry_t        youngest_entry
);

  sb_entry_t              entries_reg [DEPTH];
  logic [DEPTH-1:0]       valid_reg;
  logic [PTR_W-1:0]       head_reg;
  logic [PTR_W-1:0]       tail_reg;
  logic [CNT_W-1:0]       count_reg;
  logic [CNT_W-1:0]       count_next;
  logic [PTR_W-1:0]       youngest_slot;
  logic [PTR_W-1:0]       scan_slot;

  assign count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);
  assign head  = entries_reg[head_reg];

  // Pop clears before push sets, so a simultaneous push/pop on the same slot keeps it valid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      valid_reg <= '0;
    end else begin
      if (pop) begin
        valid_reg[head_reg] <= 1'b0;
        head_reg            <= head_reg + PTR_W'(1);
      end
      if (push) begin
        valid_reg[tail_reg] <= 1'b1;
        tail_reg            <= tail_reg + PTR_W'(1);
      end
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      entries_reg[tail_reg] <= push_entry;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    assign match_vec[gi] = valid_reg[gi] && (entries_reg[gi].idx == match_idx);
  end

  // Walk from oldest to youngest so the last hit is the youngest one.
  always_comb begin
    youngest_hit  = 1'b0;
    youngest_slot = head_reg;
    scan_slot     = head_reg;
    for (int k = 0; k < DEPTH; k++) begin
      scan_slot = head_reg + PTR_W'(k);
      if (match_vec[scan_slot]) begin
        youngest_hit  = 1'b1;
        youngest_slot = scan_slot;
      end
    end
  end

  assign youngest_entry = entries_reg[youngest_slot];

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage initiator for dmem: range/alignment checks, posted store buffer,
// one-cycle load responses. Optional store-to-load forwarding: DMEM_STORE_FWD_EN.
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter int SB_DEPTH  = SB_DEPTH_DEFAULT,
  parameter int MEM_WORDS = MEM_WORDS_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  dmem_access_unit_if.slave  bus,
  output logic               dm_we,
  output logic               dm_sb,
  output logic [31:0]        dm_a,
  output logic [31:0]        dm_wd,
  input  logic [31:0]        dm_rd
);

`ifdef DMEM_STORE_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic [29:0]         req_idx;
  logic                misalign;
  logic                out_range;
  logic                req_err;
  logic                hazard;
  logic                fwd_hit;
  logic                accept;
  logic                load_port;
  logic                fwd_accept;
  logic                push;
  logic                pop;
  logic                full;
  logic                empty;
  sb_entry_t           head;
  sb_entry_t           push_entry;
  logic [SB_DEPTH-1:0] match_vec;
  logic                youngest_hit;
  sb_entry_t           youngest_entry;

  assign req_idx   = bus.req_addr[31:2];
  // Byte stores always land in byte 0, so only word accesses care about the low bits.
  assign misalign  = (bus.req_addr[1:0] != 2'b00) && !(bus.req_we && bus.req_sb);
  assign out_range = ({2'b00, req_idx} >= 32'(MEM_WORDS));
  assign req_err   = misalign || out_range;
  assign hazard    = |match_vec;
  assign fwd_hit   = FWD_EN && youngest_hit && !youngest_entry.sb &&
                     (youngest_entry.idx == req_idx);

  always_comb begin
    bus.req_ready = 1'b0;
    if (reset) begin
      if (req_err) begin
        bus.req_ready = 1'b1;
      end else if (bus.req_we) begin
        bus.req_ready = !full;
      end else begin
        // A full buffer always drains first so loads cannot starve stores.
        bus.req_ready = !full && (!hazard || fwd_hit);
      end
    end
  end

  assign accept     = bus.req_valid && bus.req_ready;
  assign load_port  = accept && !bus.req_we && !req_err && !fwd_hit;
  assign fwd_accept = accept && !bus.req_we && !req_err && fwd_hit;
  assign push       = accept && bus.req_we && !req_err;
  assign pop        = reset && !load_port && !empty;

  assign push_entry = '{idx: req_idx, data: bus.req_wdata, sb: bus.req_sb};

  store_buf_fifo #(
    .DEPTH (SB_DEPTH)
  ) u_store_buf (
    .clk            (clk),
    .reset          (reset),
    .push           (push),
    .push_entry     (push_entry),
    .pop            (pop),
    .match_idx      (req_idx),
    .full           (full),
    .empty          (empty),
    .head           (head),
    .match_vec      (match_vec),
    .youngest_hit   (youngest_hit),
    .youngest_entry (youngest_entry)
  );

  always_comb begin
    dm_we = 1'b0;
    dm_sb = 1'b0;
    dm_a  = '0;
    dm_wd = '0;
    if (load_port) begin
      dm_a = word_addr(req_idx);
    end else if (pop) begin
      dm_we = 1'b1;
      dm_sb = head.sb;
      dm_a  = word_addr(head.idx);
      dm_wd = head.data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.err        <= 1'b0;
      bus.err_code   <= ERR_NONE;
    end else begin
      bus.resp_valid <= load_port || fwd_accept;
      if (fwd_accept) begin
        bus.resp_rdata <= youngest_entry.data;
      end else if (load_port) begin
        bus.resp_rdata <= dm_rd;
      end
      bus.err <= accept && req_err;
      if (accept && req_err) begin
        bus.err_code <= misalign ? ERR_MISALIGN : ERR_RANGE;
      end else begin
        bus.err_code <= ERR_NONE;
      end
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: a queue-based reference model of the store
// buffer and memory, checked every cycle, plus directed literal scenarios.
module tb_dmem_access_unit;

  localparam int MEM_WORDS = 10;
  localparam int SB_DEPTH  = 2;
`ifdef DMEM_STORE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    int unsigned idx;
    logic [31:0] data;
    logic        sb;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        dm_we, dm_sb;
  logic [31:0] dm_a, dm_wd, dm_rd;

  dmem_access_unit_if bus ();

  dmem_access_unit #(
    .SB_DEPTH  (SB_DEPTH),
    .MEM_WORDS (MEM_WORDS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .dm_we (dm_we),
    .dm_sb (dm_sb),
    .dm_a  (dm_a),
    .dm_wd (dm_wd),
    .dm_rd (dm_rd)
  );

  always #5 clk = ~clk;

  // Behavioural dmem: combinational read, byte or word write at the clock edge.
  logic [31:0] tb_mem   [16];
  logic [31:0] init_mem [16];
  logic        init_en;

  assign dm_rd = (dm_a[31:2] < 30'(MEM_WORDS)) ? tb_mem[dm_a[5:2]] : 32'h0;

  always @(posedge clk) begin
    if (init_en) begin
      for (int i = 0; i < 16; i++) tb_mem[i] <= init_mem[i];
    end else if (dm_we && dm_a[31:2] < 30'(MEM_WORDS)) begin
      if (dm_sb) tb_mem[dm_a[5:2]][7:0] <= dm_wd[7:0];
      else       tb_mem[dm_a[5:2]]      <= dm_wd;
    end
  end

  // Reference model state
  ent_t        q[$];
  logic [31:0] ref_mem [16];
  logic        exp_rv, exp_err;
  logic [31:0] exp_rd;
  logic [1:0]  exp_code;
  logic        chk_regs;

  int n_vec = 0;
  int n_err = 0;

  // Observed values from the latest step, used by the literal checks.
  logic        obs_ready, obs_we, obs_sb, obs_rv, obs_err;
  logic [31:0] obs_a, obs_wd, obs_rd;
  logic [1:0]  obs_code;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic step(input logic v, input logic we, input logic sb,
                      input logic [31:0] addr, input logic [31:0] wd, input logic rstn);
    int unsigned idx;
    logic mis, rng, errq, hazard, fwd, rdy, acc, loadp, drain;
    logic [31:0] fwd_data, e_a, e_wd;
    logic e_we, e_sb;
    @(negedge clk);
    obs_rv   = bus.resp_valid;
    obs_rd   = bus.resp_rdata;
    obs_err  = bus.err;
    obs_code = bus.err_code;
    if (chk_regs) begin
      chk("resp_valid", 32'(obs_rv), 32'(exp_rv));
      chk("resp_rdata", obs_rd, exp_rd);
      chk("err", 32'(obs_err), 32'(exp_err));
      chk("err_code", 32'(obs_code), 32'(exp_code));
    end
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_sb    = sb;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    reset         = rstn;
    #1;
    idx  = int'(addr[31:2]);
    mis  = (addr[1:0] != 2'b00) && !(we && sb);
    rng  = idx >= MEM_WORDS;
    errq = mis || rng;
    hazard = 1'b0;
    fwd = 1'b0;
    fwd_data = 32'h0;
    foreach (q[i]) if (q[i].idx == idx) hazard = 1'b1;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].idx == idx) begin
        fwd = FWD && !q[i].sb;
        fwd_data = q[i].data;
        break;
      end
    end
    if (!rstn)     rdy = 1'b0;
    else if (errq) rdy = 1'b1;
    else if (we)   rdy = q.size() < SB_DEPTH;
    else           rdy = (q.size() < SB_DEPTH) && (!hazard || fwd);
    acc   = rstn && v && rdy;
    loadp = acc && !we && !errq && !fwd;
    drain = rstn && !loadp && q.size() > 0;
    e_we = 1'b0; e_sb = 1'b0; e_a = 32'h0; e_wd = 32'h0;
    if (loadp) begin
      e_a = {addr[31:2], 2'b00};
    end else if (drain) begin
      e_we = 1'b1;
      e_sb = q[0].sb;
      e_a  = q[0].idx << 2;
      e_wd = q[0].data;
    end
    obs_ready = bus.req_ready;
    obs_we = dm_we; obs_sb = dm_sb; obs_a = dm_a; obs_wd = dm_wd;
    chk("req_ready", 32'(obs_ready), 32'(rdy));
    chk("dm_we", 32'(obs_we), 32'(e_we));
    chk("dm_sb", 32'(obs_sb), 32'(e_sb));
    chk("dm_a", obs_a, e_a);
    chk("dm_wd", obs_wd, e_wd);
    if (!rstn) begin
      q.delete();
      exp_rv = 1'b0; exp_rd = 32'h0; exp_err = 1'b0; exp_code = 2'b00;
    end else begin
      exp_rv = acc && !we && !errq;
      if (exp_rv) exp_rd = fwd ? fwd_data : ref_mem[idx];
      exp_err  = acc && errq;
      exp_code = !exp_err ? 2'b00 : (mis ? 2'b01 : 2'b10);
      if (drain) begin
        if (q[0].sb) ref_mem[q[0].idx][7:0] = q[0].data[7:0];
        else         ref_mem[q[0].idx]      = q[0].data;
        void'(q.pop_front());
      end
      if (acc && we && !errq) q.push_back('{idx: idx, data: wd, sb: sb});
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
  endtask

  initial begin
    logic [31:0] addr;
    logic        v, we, sb, rstn;
    for (int i = 0; i < 16; i++) init_mem[i] = $urandom;
    init_mem[0] = 32'h11223344;
    init_mem[2] = 32'hDEADBEEF;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_mem[i];
    init_en  = 1'b1;
    chk_regs = 1'b0;
    exp_rv = 1'b0; exp_rd = 32'h0; exp_err = 1'b0; exp_code = 2'b00;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_sb = 1'b0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    reset = 1'b0;

    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    init_en  = 1'b0;
    chk_regs = 1'b1;
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    idle();
    chk("lit_rst_resp_valid", 32'(obs_rv), 32'h0);
    chk("lit_rst_resp_rdata", obs_rd, 32'h0);
    chk("lit_rst_err", 32'(obs_err), 32'h0);
    chk("lit_rst_dm_we", 32'(obs_we), 32'h0);

    // Plain load with latency 1
    step(1'b1, 1'b0, 1'b0, 32'h8, 32'h0, 1'b1);
    chk("lit_t1_dm_a", obs_a, 32'h8);
    chk("lit_t1_ready", 32'(obs_ready), 32'h1);
    idle();
    chk("lit_t1_resp_valid", 32'(obs_rv), 32'h1);
    chk("lit_t1_rdata", obs_rd, 32'hDEADBEEF);

    // Store then dependent load
    step(1'b1, 1'b1, 1'b0, 32'h4, 32'h1234, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'h4, 32'h0, 1'b1);
`ifdef DMEM_STORE_FWD_EN
    chk("lit_t2_fwd_ready", 32'(obs_ready), 32'h1);
`else
    chk("lit_t2_stall_ready", 32'(obs_ready), 32'h0);
    chk("lit_t2_drain_we", 32'(obs_we), 32'h1);
    chk("lit_t2_drain_a", obs_a, 32'h4);
    chk("lit_t2_drain_wd", obs_wd, 32'h1234);
    step(1'b1, 1'b0, 1'b0, 32'h4, 32'h0, 1'b1);
    chk("lit_t2_retry_ready", 32'(obs_ready), 32'h1);
`endif
    idle();
    chk("lit_t2_rdata", obs_rd, 32'h1234);

    // Error cases
    step(1'b1, 1'b0, 1'b0, 32'h6, 32'h0, 1'b1);
    chk("lit_t4_mis_ready", 32'(obs_ready), 32'h1);
    chk("lit_t4_mis_dm_we", 32'(obs_we), 32'h0);
    idle();
    chk("lit_t4_mis_err", 32'(obs_err), 32'h1);
    chk("lit_t4_mis_code", 32'(obs_code), 32'h1);
    chk("lit_t4_mis_rv", 32'(obs_rv), 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h28, 32'h55, 1'b1);
    idle();
    chk("lit_t4_rng_code", 32'(obs_code), 32'h2);

    // Byte store, then a load to the same word stalls in every build
    step(1'b1, 1'b1, 1'b1, 32'h0, 32'h000000AB, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    chk("lit_t5_stall_ready", 32'(obs_ready), 32'h0);
    chk("lit_t5_drain_sb", 32'(obs_sb), 32'h1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    idle();
    chk("lit_t5_rdata", obs_rd, 32'h112233AB);

    // Reset discards a queued store
    step(1'b1, 1'b1, 1'b0, 32'h10, 32'hCAFEF00D, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    idle();
    chk("lit_t6_dm_we", 32'(obs_we), 32'h0);
    chk("lit_t6_word4", tb_mem[4], init_mem[4]);

    // Randomised traffic around a few hot words and the range boundary
    for (int n = 0; n < 3000; n++) begin
      v  = ($urandom_range(0, 9) < 7);
      we = $urandom_range(0, 1);
      sb = we && ($urandom_range(0, 9) < 3);
      addr = 32'($urandom_range(0, 11)) << 2;
      if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) addr = $urandom;
      rstn = ($urandom_range(0, 149) != 0);
      step(v, we, sb, addr, $urandom, rstn);
    end
    idle();
    idle();
    for (int i = 0; i < MEM_WORDS; i++) chk($sformatf("mem_word%0d", i), tb_mem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
